ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter and sequencer for the 8-bit × 64K simple dual-port RAM. It shares the RAM write port between two writers and the read port between two readers, each through a valid/ready handshake. It returns read data, tagged with the requester ID, aligned to the RAM's one-cycle registered read latency. It enforces write-first ordering on same-cycle same-address collisions and sits directly in front of the RAM instance, in the same clock domain as both RAM ports.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  single clock; drives the arbiter and both RAM clock inputs
- rst  in  1  asynchronous, active-high reset
- w0_valid / w1_valid  in  1  write request from writer 0 / writer 1
- w0_addr / w1_addr  in  ADDR_W  write address
- w0_data / w1_data  in  DATA_W  write data
- w0_ready / w1_ready  out  1  write accepted this cycle
- r0_valid / r1_valid  in  1  read request from reader 0 / reader 1
- r0_addr / r1_addr  in  ADDR_W  read address
- r0_ready / r1_ready  out  1  read accepted this cycle
- rsp_valid  out  1  read data valid
- rsp_id  out  1  reader that owns rsp_data
- rsp_data  out  DATA_W  read data (passthrough of ram_q)
- ram_we  out  1  RAM write enable
- ram_write_addr  out  ADDR_W  RAM write address
- ram_data  out  DATA_W  RAM write data
- ram_read_addr  out  ADDR_W  RAM read address
- ram_q  in  DATA_W  RAM registered output

## Operation
- A transfer occurs when valid && ready in the same cycle. Ready depends combinationally on the valids, the arbitration pointers and the collision check. Requesters hold valid, addr and data stable until ready.
- Write port:
  - At most one writer is granted per cycle.
  - ram_we = w0_ready | w1_ready.
  - ram_write_addr and ram_data are muxed from the granted writer. They are don't-care when ram_we=0 and are driven 0 in that case.
- Read port:
  - At most one reader is granted per cycle.
  - ram_read_addr is muxed from the granted reader. It is 0 when no reader is granted.
- Arbitration: each port has an independent 1-bit pointer, wr_ptr and rd_ptr.
  - The pointed-to requester has priority.
  - After a grant, the pointer moves to the other requester.
  - With a single requester active, that requester is granted every cycle.
- Collision rule: the winning reader's address equals ram_write_addr while ram_we=1.
  - The read is not granted that cycle; its ready stays 0.
  - rd_ptr is unchanged.
  - The read is granted on a later cycle and returns the newly written data (write-first).
  - The other reader is not promoted into the blocked slot.
- Response pipeline:
  - rsp_valid_q <= read granted.
  - rsp_id_q <= granted reader index.
  - rsp_data = ram_q.
  - Responses have no backpressure; readers must accept rsp_valid in the cycle it is asserted.
- Reset (asynchronous, any time):
  - All readies are 0 while rst=1.
  - ram_we=0, rsp_valid=0, rsp_id=0.
  - wr_ptr=0, rd_ptr=0.
  - An in-flight read response is dropped: rsp_valid falls immediately and is not reissued.

## Timing
- Write latency: the RAM is updated at the clk edge ending the handshake cycle.
- Read latency: 1 cycle. The handshake occurs in cycle N; rsp_valid, rsp_id and rsp_data are valid in cycle N+1.
- Throughput: 1 write and 1 read per cycle when there is no collision.
- A collision adds ≥1 cycle to the blocked read.
- First grant after rst deassertion: the first cycle following the deassertion.

## Configuration
- Macro: RAM_PORT_ARBITER_RR_EN.
- Defined: round-robin pointers as described under Operation.
- Undefined:
  - Fixed priority on both ports; requester 0 always wins.
  - Pointer registers are removed.
  - The collision rule is unchanged.

## Structure
- Shared package ram_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The NREQ=2 constant.
  - A typedef for the requester index.
- Sub-module rr_arb2 is instantiated twice, once for the write port and once for the read port.
  - Inputs: clk, rst, req[1:0], en (the grant-allowed qualifier, used for collision blocking).
  - Outputs: gnt[1:0] (one-hot or zero).
  - rr_arb2 contains the pointer logic and honours RAM_PORT_ARBITER_RR_EN.

## Test plan
- Reset: assert rst mid-read. Next cycle rsp_valid=0, all readies=0, ram_we=0. After release, w1 alone gets w1_ready in the first cycle.
- Write contention: w0 and w1 both valid for 4 cycles with RR. Grants alternate 0,1,0,1. Without the macro: 0,0,0,0.
- Read return: write 0xA5 to addr 0x1234, then r1 reads 0x1234. One cycle after r1_ready: rsp_valid=1, rsp_id=1, rsp_data=0xA5.
- Collision: w0 writes 0x3C to 0x00FF while r0 reads 0x00FF in the same cycle. r0_ready=0 that cycle and 1 the next. The response returns 0x3C.
- Concurrent ports: w0 writes 0x0001 while r1 reads 0x0002 in the same cycle. Both readies are 1 and there is no stall.
- Address wrap: write 0x7E to 0xFFFF and 0x81 to 0x0000. Reads return 0x7E and 0x81 respectively.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: default widths, requester
// count and the requester index type.
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int NREQ       = 2;

  typedef logic req_id_t;

  // Index of the set bit in a one-hot (or zero) two-bit grant vector.
  function automatic req_id_t onehot_to_id(input logic [NREQ-1:0] oh);
    return oh[1];
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter. With RAM_PORT_ARBITER_RR_EN defined it keeps a
// round-robin pointer; otherwise requester 0 has fixed priority.
// 'pick' is the winner before the 'en' qualifier so the caller can test the
// winner (e.g. for an address collision) and then suppress the grant without
// disturbing the pointer.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] pick,
  output logic [NREQ-1:0] gnt
);

`ifdef RAM_PORT_ARBITER_RR_EN
  req_id_t ptr;

  // Pointed-to requester first, otherwise the other one.
  always_comb begin
    pick = '0;
    if (req[ptr])       pick[ptr]  = 1'b1;
    else if (req[~ptr]) pick[~ptr] = 1'b1;
  end

  // After a grant, priority moves to the requester that did not win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= 1'b0;
    else if (|gnt) ptr <= ~onehot_to_id(gnt);
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Requester 0 always wins.
  always_comb begin
    pick = '0;
    if (req[0])      pick[0] = 1'b1;
    else if (req[1]) pick[1] = 1'b1;
  end
`endif

  assign gnt = en ? pick : '0;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter/sequencer in front of a simple dual-port RAM: two writers share the
// write port, two readers share the read port, read data comes back one cycle
// later tagged with the reader id. A read whose address matches the write
// happening in the same cycle is held off so it later returns the new data.
// Optional macro: RAM_PORT_ARBITER_RR_EN (round-robin instead of fixed
// priority on both ports).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w0_valid,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_ready,
  input  logic              w1_valid,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_ready,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q
);

  logic [NREQ-1:0] w_pick, w_gnt;
  logic [NREQ-1:0] r_pick, r_gnt;
  logic [ADDR_W-1:0] r_pick_addr;
  logic collision;
  logic rsp_valid_q;
  req_id_t rsp_id_q;

  rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({w1_valid, w0_valid}),
    .en   (~rst),
    .pick (w_pick),
    .gnt  (w_gnt)
  );

  assign w0_ready = w_gnt[0];
  assign w1_ready = w_gnt[1];
  assign ram_we   = |w_gnt;

  // Write port mux; idle port drives zeros.
  always_comb begin
    ram_write_addr = '0;
    ram_data       = '0;
    if (w_gnt[1]) begin
      ram_write_addr = w1_addr;
      ram_data       = w1_data;
    end else if (w_gnt[0]) begin
      ram_write_addr = w0_addr;
      ram_data       = w0_data;
    end
  end

  // The winning reader is blocked, not replaced, when it hits the write address.
  assign r_pick_addr = r_pick[1] ? r1_addr : r0_addr;
  assign collision   = ram_we && (|r_pick) && (r_pick_addr == ram_write_addr);

  rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({r1_valid, r0_valid}),
    .en   (~rst & ~collision),
    .pick (r_pick),
    .gnt  (r_gnt)
  );

  assign r0_ready = r_gnt[0];
  assign r1_ready = r_gnt[1];

  // Read port mux; zero when no reader is granted.
  always_comb begin
    ram_read_addr = '0;
    if (r_gnt[1])      ram_read_addr = r1_addr;
    else if (r_gnt[0]) ram_read_addr = r0_addr;
  end

  // Response tag tracks the RAM's one-cycle registered read; reset drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      rsp_valid_q <= |r_gnt;
      rsp_id_q    <= onehot_to_id(r_gnt);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM attached.
// Build with or without RAM_PORT_ARBITER_RR_EN; expectations follow the macro.
module tb_ram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
`ifdef RAM_PORT_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w0_valid = 0, w1_valid = 0, r0_valid = 0, r1_valid = 0;
  logic [AW-1:0] w0_addr = '0, w1_addr = '0, r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] w0_data = '0, w1_data = '0;
  logic w0_ready, w1_ready, r0_ready, r1_ready;
  logic rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;
  logic ram_we;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  // Behavioural simple dual-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  task automatic idle_all();
    w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    r0_valid = 1; r0_addr = 16'h0010;
    @(negedge clk);
    n_checks++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pre_read r0_ready got %b want 1", r0_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL reset_inflight rsp_valid got %b want 1", rsp_valid); end
    w0_valid = 1; w0_addr = 16'h0020; w0_data = 8'h55; r1_valid = 1; r1_addr = 16'h0030;
    rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if ({w0_ready, w1_ready, r0_ready, r1_ready} !== 4'b0000) begin n_fail++; $display("FAIL reset_readies got %b want 0000", {w0_ready, w1_ready, r0_ready, r1_ready}); end
    n_checks++; if (ram_we !== 1'b0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_we_id got we=%b id=%b want 0,0", ram_we, rsp_id); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_reissue rsp_valid got %b want 0", rsp_valid); end
    idle_all();
    rst = 1'b0;
    w1_valid = 1; w1_addr = 16'h0040; w1_data = 8'h66;
    @(negedge clk);
    n_checks++; if (w1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant w1_ready got %b want 1", w1_ready); end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_contention();
    do_reset();
    w0_valid = 1; w0_addr = 16'h0100; w0_data = 8'h01;
    w1_valid = 1; w1_addr = 16'h0200; w1_data = 8'h02;
    for (int i = 0; i < 4; i++) begin
      int exp_win;
      exp_win = RR ? (i % 2) : 0;
      @(negedge clk);
      n_checks++;
      if ({w1_ready, w0_ready} !== ((exp_win == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL contention_%0d grants got w1w0=%b want winner %0d", i, {w1_ready, w0_ready}, exp_win);
      end
      @(posedge clk); #1;
    end
    idle_all();
  endtask

  task automatic test_read_return();
    do_reset();
    w0_valid = 1; w0_addr = 16'h1234; w0_data = 8'hA5;
    @(negedge clk);
    n_checks++; if (w0_ready !== 1'b1) begin n_fail++; $display("FAIL rdret_write w0_ready got %b want 1", w0_ready); end
    @(posedge clk); #1;
    w0_valid = 0;
    r1_valid = 1; r1_addr = 16'h1234;
    @(negedge clk);
    n_checks++; if (r1_ready !== 1'b1 || ram_read_addr !== 16'h1234) begin n_fail++; $display("FAIL rdret_grant got ready=%b addr=%h want 1,1234", r1_ready, ram_read_addr); end
    @(posedge clk); #1;
    r1_valid = 0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'hA5) begin n_fail++; $display("FAIL rdret_rsp got v=%b id=%b d=%h want 1,1,a5", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_collision();
    do_reset();
    w0_valid = 1; w0_addr = 16'h00FF; w0_data = 8'h3C;
    r0_valid = 1; r0_addr = 16'h00FF;
    @(negedge clk);
    n_checks++; if (w0_ready !== 1'b1 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL collision_block got w0=%b r0=%b r1=%b want 1,0,0", w0_ready, r0_ready, r1_ready); end
    @(posedge clk); #1;
    w0_valid = 0;
    @(negedge clk);
    n_checks++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL collision_retry r0_ready got %b want 1", r0_ready); end
    @(posedge clk); #1;
    r0_valid = 0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h3C) begin n_fail++; $display("FAIL collision_rsp got v=%b id=%b d=%h want 1,0,3c", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_concurrent();
    do_reset();
    w0_valid = 1; w0_addr = 16'h0001; w0_data = 8'h11;
    r1_valid = 1; r1_addr = 16'h0002;
    @(negedge clk);
    n_checks++; if (w0_ready !== 1'b1 || r1_ready !== 1'b1) begin n_fail++; $display("FAIL concurrent got w0=%b r1=%b want 1,1", w0_ready, r1_ready); end
    n_checks++; if (ram_write_addr !== 16'h0001 || ram_data !== 8'h11 || ram_read_addr !== 16'h0002) begin n_fail++; $display("FAIL concurrent_mux got wa=%h d=%h ra=%h want 0001,11,0002", ram_write_addr, ram_data, ram_read_addr); end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_wrap();
    do_reset();
    w0_valid = 1; w0_addr = 16'hFFFF; w0_data = 8'h7E;
    @(posedge clk); #1;
    w0_addr = 16'h0000; w0_data = 8'h81;
    @(posedge clk); #1;
    w0_valid = 0;
    r0_valid = 1; r0_addr = 16'hFFFF;
    @(posedge clk); #1;
    r0_addr = 16'h0000;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h7E) begin n_fail++; $display("FAIL wrap_ffff got v=%b d=%h want 1,7e", rsp_valid, rsp_data); end
    @(posedge clk); #1;
    r0_valid = 0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h81) begin n_fail++; $display("FAIL wrap_0000 got v=%b d=%h want 1,81", rsp_valid, rsp_data); end
  endtask

  // Random traffic on a small address window to force contention and
  // collisions, checked against a transaction-level model.
  task automatic test_random(input int ncyc);
    bit wptr, rptr;
    bit pend_v, pend_id;
    logic [DW-1:0] pend_d;
    do_reset();
    wptr = 0; rptr = 0; pend_v = 0; pend_id = 0; pend_d = '0;
    for (int a = 16'h4000; a < 16'h4004; a++) ref_mem[a] = mem[a];
    for (int c = 0; c < ncyc; c++) begin
      bit wg, rg, wwin, rwin, rhas;
      logic [AW-1:0] ewa, era, rcand;
      logic [DW-1:0] ewd;
      @(negedge clk);
      wg = w0_valid | w1_valid;
      wwin = (w0_valid && w1_valid) ? (RR ? wptr : 1'b0) : w1_valid && !w0_valid;
      ewa = wg ? (wwin ? w1_addr : w0_addr) : '0;
      ewd = wg ? (wwin ? w1_data : w0_data) : '0;
      rhas = r0_valid | r1_valid;
      rwin = (r0_valid && r1_valid) ? (RR ? rptr : 1'b0) : r1_valid && !r0_valid;
      rcand = rwin ? r1_addr : r0_addr;
      rg = rhas && !(wg && rcand == ewa);
      era = rg ? rcand : '0;
      n_checks++;
      if ({w1_ready, w0_ready, ram_we} !== {wg && wwin, wg && !wwin, wg} || ram_write_addr !== ewa || ram_data !== ewd) begin
        n_fail++; $display("FAIL rand_wr cyc %0d got w1w0we=%b wa=%h d=%h want %b wa=%h d=%h", c, {w1_ready, w0_ready, ram_we}, ram_write_addr, ram_data, {wg && wwin, wg && !wwin, wg}, ewa, ewd);
      end
      n_checks++;
      if ({r1_ready, r0_ready} !== {rg && rwin, rg && !rwin} || ram_read_addr !== era) begin
        n_fail++; $display("FAIL rand_rd cyc %0d got r1r0=%b ra=%h want %b ra=%h", c, {r1_ready, r0_ready}, ram_read_addr, {rg && rwin, rg && !rwin}, era);
      end
      n_checks++;
      if (rsp_valid !== pend_v || (pend_v && (rsp_id !== pend_id || rsp_data !== pend_d))) begin
        n_fail++; $display("FAIL rand_rsp cyc %0d got v=%b id=%b d=%h want v=%b id=%b d=%h", c, rsp_valid, rsp_id, rsp_data, pend_v, pend_id, pend_d);
      end
      pend_v = rg; pend_id = rwin;
      if (rg) begin pend_d = ref_mem[era]; if (RR) rptr = ~rwin; end
      if (wg) begin ref_mem[ewa] = ewd; if (RR) wptr = ~wwin; end
      @(posedge clk); #1;
      if (!w0_valid || (wg && !wwin)) begin w0_valid = $urandom_range(0, 1); w0_addr = 16'h4000 + AW'($urandom_range(0, 3)); w0_data = DW'($urandom); end
      if (!w1_valid || (wg && wwin))  begin w1_valid = $urandom_range(0, 1); w1_addr = 16'h4000 + AW'($urandom_range(0, 3)); w1_data = DW'($urandom); end
      if (!r0_valid || (rg && !rwin)) begin r0_valid = $urandom_range(0, 1); r0_addr = 16'h4000 + AW'($urandom_range(0, 3)); end
      if (!r1_valid || (rg && rwin))  begin r1_valid = $urandom_range(0, 1); r1_addr = 16'h4000 + AW'($urandom_range(0, 3)); end
    end
    idle_all();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin mem[a] = '0; ref_mem[a] = '0; end
    test_reset();
    test_contention();
    test_read_return();
    test_collision();
    test_concurrent();
    test_wrap();
    test_random(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
